// File: rtl/wb_sram8_bridge_pkg.sv
// Shared definitions for the Wishbone-to-8-bit-SRAM bridge: FSM encodings,
// default strobe timing and the inactive level of the active-low SRAM strobes.
package wb_sram8_bridge_pkg;

    localparam int   DEF_WAIT_STATES = 2;
    localparam logic STROBE_IDLE     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_R0   = 3'd2,
        ST_B1   = 3'd3,
        ST_R1   = 3'd4,
        ST_ACK  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_STROBE = 2'd1,
        PH_RECOV  = 2'd2
    } phase_t;

endpackage

// File: rtl/wb_sram8_bridge_if.sv
// CPU-side Wishbone bundle of the SRAM bridge.
// Handshake: stb is a request the slave samples only while idle; ack is a
// single-cycle pulse when the access has finished; dat_r is valid while ack is high.
interface wb_sram8_bridge_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] adr;
    logic [15:0]       dat_w;
    logic [15:0]       dat_r;
    logic              we;
    logic              byte_acc;
    logic              mio;
    logic              stb;
    logic              ack;

    modport master (
        output adr, dat_w, we, byte_acc, mio, stb,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, byte_acc, mio, stb,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_sram8_phase.sv
// One SRAM byte access: strobe for WAIT_STATES cycles, then one recovery cycle.
// start is honoured when idle or recovering, so two phases can run back to back.
module wb_sram8_phase
    import wb_sram8_bridge_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              last,
    output logic              done,
    output logic [7:0]        rdata,
    output phase_t            state,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [7:0]        sram_rdata,
    output logic [7:0]        sram_wdata,
    output logic              sram_drive,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

    phase_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q;
    logic       load;

    assign load = start && (state_q != PH_STROBE);
    assign last = (state_q == PH_STROBE) && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            PH_IDLE:   if (start) state_d = PH_STROBE;
            PH_STROBE: begin
                if (last) begin
                    state_d = PH_RECOV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PH_RECOV:  state_d = start ? PH_STROBE : PH_IDLE;
            default:   state_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PH_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                we_q       <= we;
                sram_addr  <= addr;
                sram_wdata <= wdata;
            end
            // Sample at the end of the strobe so the SRAM has had its full access time.
            if (last && !we_q) rdata <= sram_rdata;
        end
    end

    assign state      = state_q;
    assign done       = (state_q == PH_RECOV);
    assign sram_drive = (state_q != PH_IDLE) && we_q;
    assign sram_ce_n  = (state_q == PH_IDLE) ? STROBE_IDLE : ~STROBE_IDLE;
    assign sram_oe_n  = (state_q == PH_STROBE && !we_q) ? ~STROBE_IDLE : STROBE_IDLE;
    assign sram_we_n  = (state_q == PH_STROBE &&  we_q) ? ~STROBE_IDLE : STROBE_IDLE;

endmodule

// File: rtl/wb_sram8_bridge.sv
// Wishbone slave turning 16-bit byte-addressed memory cycles into one or two
// 8-bit asynchronous SRAM accesses (low byte at adr, high byte at adr+1).
module wb_sram8_bridge
    import wb_sram8_bridge_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int ADDR_W      = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_sram8_bridge_if.slave  wb,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [7:0]        sram_data_i,
    output logic [7:0]        sram_data_o,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output state_t            dbg_state,
    output phase_t            dbg_phase
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q;
    logic [7:0]        dat_hi_q;
    logic              we_q, byte_q;
    logic [7:0]        lo_q;
    logic [15:0]       dat_r_q;

    logic              accept;
    logic              ph_start, ph_we, ph_last, ph_done;
    logic [ADDR_W-1:0] ph_addr;
    logic [7:0]        ph_wdata, ph_rdata;

    assign accept = (state_q == ST_IDLE) && wb.stb && wb.mio;

    always_comb begin
        state_d  = state_q;
        ph_start = 1'b0;
        ph_we    = we_q;
        ph_addr  = adr_q + ADDR_W'(1);
        ph_wdata = dat_hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_B0;
                    ph_start = 1'b1;
                    ph_we    = wb.we;
                    ph_addr  = wb.adr;
                    ph_wdata = wb.dat_w[7:0];
                end
            end
            ST_B0:   if (ph_last) state_d = ST_R0;
            ST_R0: begin
                if (ph_done) begin
                    if (byte_q) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d  = ST_B1;
                        ph_start = 1'b1;
                    end
                end
            end
            ST_B1:   if (ph_last) state_d = ST_R1;
            ST_R1:   if (ph_done) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            dat_hi_q <= '0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            lo_q     <= '0;
            dat_r_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                adr_q    <= wb.adr;
                dat_hi_q <= wb.dat_w[15:8];
                we_q     <= wb.we;
                byte_q   <= wb.byte_acc;
            end
            if (state_q == ST_R0 && !we_q) begin
                if (byte_q) dat_r_q <= {8'h00, ph_rdata};
                else        lo_q    <= ph_rdata;
            end
            if (state_q == ST_R1 && !we_q) dat_r_q <= {ph_rdata, lo_q};
        end
    end

    assign wb.ack    = (state_q == ST_ACK);
    assign wb.dat_r  = dat_r_q;
    assign dbg_state = state_q;

    wb_sram8_phase #(
        .WAIT_STATES (WAIT_STATES),
        .ADDR_W      (ADDR_W)
    ) u_phase (
        .clk        (clk_i),
        .rst        (rst_i),
        .start      (ph_start),
        .we         (ph_we),
        .addr       (ph_addr),
        .wdata      (ph_wdata),
        .last       (ph_last),
        .done       (ph_done),
        .rdata      (ph_rdata),
        .state      (dbg_phase),
        .sram_addr  (sram_addr_o),
        .sram_rdata (sram_data_i),
        .sram_wdata (sram_data_o),
        .sram_drive (sram_data_oe_o),
        .sram_ce_n  (sram_ce_n_o),
        .sram_oe_n  (sram_oe_n_o),
        .sram_we_n  (sram_we_n_o)
    );

endmodule

// File: tb/tb_wb_sram8_bridge.sv
// Bench for wb_sram8_bridge: SRAM model, strobe monitor, reference memory
// and directed plus random Wishbone memory cycles.
module tb_wb_sram8_bridge;
    import wb_sram8_bridge_pkg::*;

    localparam int W  = 2;
    localparam int AW = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_sram8_bridge_if #(.ADDR_W(AW)) wb ();

    logic [AW-1:0] sram_addr_o;
    logic [7:0]    sram_data_i = 8'hEE;
    logic [7:0]    sram_data_o;
    logic          sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    state_t        dut_state;
    phase_t        dut_phase;

    wb_sram8_bridge #(.WAIT_STATES(W), .ADDR_W(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wb             (wb),
        .sram_addr_o    (sram_addr_o),
        .sram_data_i    (sram_data_i),
        .sram_data_o    (sram_data_o),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .dbg_state      (dut_state),
        .dbg_phase      (dut_phase)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int ce_cnt = 0;
    int inv_bad = 0;
    int oe_run = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            len;
        int            start;
        logic          stable;
    } ev_t;

    ev_t         ev_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  mem[int];
    logic [7:0]  ref_mem[int];

    function automatic logic [7:0] dflt(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : dflt(int'(a));
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(int'(a));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
        mem[int'(a)]     = v;
        ref_mem[int'(a)] = v;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read port: data is only valid in the last cycle of an oe_n pulse of length W.
    always @(negedge clk) begin
        if (!sram_ce_n_o && !sram_oe_n_o) begin
            oe_run      <= oe_run + 1;
            sram_data_i <= (oe_run + 1 == W) ? mem_rd(sram_addr_o) : 8'hEE;
        end else begin
            oe_run      <= 0;
            sram_data_i <= 8'hEE;
        end
    end

    // Strobe monitor: SRAM writes, pulse records and bus invariants.
    logic          in_run = 1'b0;
    logic          r_wr, r_ok;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;
    int            r_len, r_start;

    always @(negedge clk) begin
        if (wb.ack) ack_cnt++;
        if (!sram_ce_n_o) ce_cnt++;
        if (!sram_oe_n_o && !sram_we_n_o) inv_bad++;
        if (!sram_we_n_o && !sram_data_oe_o) inv_bad++;
        if (!sram_we_n_o && !sram_ce_n_o) mem[int'(sram_addr_o)] = sram_data_o;
        if (!sram_oe_n_o || !sram_we_n_o) begin
            if (!in_run) begin
                in_run  = 1'b1;
                r_wr    = !sram_we_n_o;
                r_addr  = sram_addr_o;
                r_data  = sram_data_o;
                r_len   = 1;
                r_start = cyc;
                r_ok    = !sram_ce_n_o;
            end else begin
                r_len++;
                if (sram_ce_n_o || sram_addr_o !== r_addr || r_wr !== !sram_we_n_o ||
                    (r_wr && sram_data_o !== r_data)) r_ok = 1'b0;
            end
        end else if (in_run) begin
            in_run = 1'b0;
            if (sram_ce_n_o || sram_addr_o !== r_addr ||
                (r_wr && (sram_data_o !== r_data || !sram_data_oe_o))) r_ok = 1'b0;
            ev_q.push_back('{r_wr, r_addr, r_data, r_len, r_start, r_ok});
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input logic wr, input logic bt, input logic [AW-1:0] a,
                             input logic [15:0] d, input string tag);
        int            c0;
        int            nb;
        bit            got;
        logic [AW-1:0] ea;
        nb = bt ? 1 : 2;
        ev_q.delete();
        exp_q.delete();
        ea = a + 20'd1;
        if (wr) begin
            ref_mem[int'(a)] = d[7:0];
            if (!bt) ref_mem[int'(ea)] = d[15:8];
        end else begin
            exp_q.push_back(bt ? {8'h00, ref_rd(a)} : {ref_rd(ea), ref_rd(a)});
        end
        @(negedge clk);
        wb.adr = a; wb.dat_w = d; wb.we = wr; wb.byte_acc = bt; wb.mio = 1'b1; wb.stb = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        wb.stb      = 1'b0;
        wb.adr      = AW'($urandom);
        wb.dat_w    = 16'($urandom);
        wb.we       = 1'($urandom);
        wb.byte_acc = 1'($urandom);
        wb.mio      = 1'($urandom);
        got = 1'b0;
        for (int n = 0; n < 8 * W + 20 && !got; n++) begin
            @(negedge clk);
            if (wb.ack) got = 1'b1;
        end
        check({tag, " ack seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " latency"}, 32'(cyc - c0), 32'(bt ? W + 2 : 2 * W + 3));
            check({tag, " ce_n in ack"}, 32'(sram_ce_n_o), 32'd1);
            check({tag, " data_oe in ack"}, 32'(sram_data_oe_o), 32'd0);
            if (!wr) check({tag, " dat_o"}, 32'(wb.dat_r), 32'(exp_q.pop_front()));
            check({tag, " strobe count"}, 32'(ev_q.size()), 32'(nb));
            for (int i = 0; i < nb && i < ev_q.size(); i++) begin
                ea = a + AW'(i);
                check({tag, " strobe kind"}, 32'(ev_q[i].wr), 32'(wr));
                check({tag, " strobe addr"}, 32'(ev_q[i].addr), 32'(ea));
                check({tag, " strobe len"}, 32'(ev_q[i].len), 32'(W));
                check({tag, " strobe start"}, 32'(ev_q[i].start - c0), 32'(1 + i * (W + 1)));
                check({tag, " strobe stable"}, 32'(ev_q[i].stable), 32'd1);
                if (wr) check({tag, " strobe data"}, 32'(ev_q[i].data), 32'(d[8 * i +: 8]));
            end
        end
        @(negedge clk);
        check({tag, " ack pulse"}, 32'(wb.ack), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            a0, ce0, c0;
        logic          wr, bt;
        logic [AW-1:0] a;
        logic [AW-1:0] pool[8];
        pool = '{20'h00000, 20'h00001, 20'h00100, 20'h00101,
                 20'h12345, 20'h12346, 20'hFFFFE, 20'hFFFFF};

        rst = 1'b1;
        wb.adr = '0; wb.dat_w = '0; wb.we = 1'b0; wb.byte_acc = 1'b0;
        wb.mio = 1'b0; wb.stb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(wb.ack), 32'd0);
        check("reset dat_o", 32'(wb.dat_r), 32'd0);
        check("reset addr", 32'(sram_addr_o), 32'd0);
        check("reset wdata", 32'(sram_data_o), 32'd0);
        check("reset data_oe", 32'(sram_data_oe_o), 32'd0);
        check("reset strobes", 32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o}), 32'h7);
        check("reset state", 32'(dut_state), 32'(ST_IDLE));
        rst = 1'b0;

        preload(20'h01234, 8'hA5);
        do_access(1'b0, 1'b1, 20'h01234, 16'h0000, "byte read");
        do_access(1'b1, 1'b0, 20'h00100, 16'hBEEF, "word write");
        do_access(1'b0, 1'b0, 20'h00100, 16'h0000, "word readback");
        preload(20'h12345, 8'h34);
        preload(20'h12346, 8'h12);
        do_access(1'b0, 1'b0, 20'h12345, 16'h0000, "unaligned read");
        preload(20'hFFFFF, 8'h11);
        preload(20'h00000, 8'h22);
        do_access(1'b0, 1'b0, 20'hFFFFF, 16'h0000, "wrap read");
        do_access(1'b1, 1'b1, 20'h00101, 16'h77C3, "byte write");
        do_access(1'b0, 1'b0, 20'h00100, 16'h0000, "byte write readback");

        // I/O cycle must be ignored entirely.
        @(negedge clk);
        a0 = ack_cnt; ce0 = ce_cnt;
        wb.adr = 20'h00040; wb.we = 1'b0; wb.byte_acc = 1'b0; wb.mio = 1'b0; wb.stb = 1'b1;
        repeat (10) @(negedge clk);
        wb.stb = 1'b0;
        check("io ce_n", 32'(ce_cnt - ce0), 32'd0);
        check("io ack", 32'(ack_cnt - a0), 32'd0);

        // Reset in cycle 5 of a word write.
        ev_q.delete();
        @(negedge clk);
        wb.adr = 20'h00200; wb.dat_w = 16'hCAFE; wb.we = 1'b1; wb.byte_acc = 1'b0;
        wb.mio = 1'b1; wb.stb = 1'b1;
        c0 = cyc; a0 = ack_cnt;
        @(posedge clk);
        #1 wb.stb = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst cycle", 32'(cyc - c0), 32'd5);
        check("rst pre we_n", 32'(sram_we_n_o), 32'd0);
        check("rst pre addr", 32'(sram_addr_o), 32'h00201);
        @(posedge clk);
        #1;
        check("rst we_n", 32'(sram_we_n_o), 32'd1);
        check("rst data_oe", 32'(sram_data_oe_o), 32'd0);
        check("rst ce_n", 32'(sram_ce_n_o), 32'd1);
        check("rst addr", 32'(sram_addr_o), 32'd0);
        check("rst state", 32'(dut_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst no ack", 32'(ack_cnt - a0), 32'd0);
        preload(20'h03333, 8'h5E);
        do_access(1'b0, 1'b1, 20'h03333, 16'h0000, "post-reset read");

        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
            do_access(wr, bt, a, 16'($urandom), wr ? "rand write" : "rand read");
        end

        check("strobe invariants", 32'(inv_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sram8_bridge.md
Name: wb_sram8_bridge

Overview:
- Wishbone slave directly downstream of the CPU bus master. Converts the CPU's 16-bit, byte-addressed memory cycles into accesses on an external 8-bit asynchronous SRAM.
- Word accesses become two byte accesses: low byte at adr, high byte at adr+1. Unaligned addresses are supported.
- Only memory cycles are served (mio_i=1). I/O cycles are left to a separate I/O slave.

Parameters:
- WAIT_STATES, 2, cycles oe_n/we_n held low per byte access (legal range 1..15).
- ADDR_W, 20, byte address width on both sides.

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- adr_i  in  ADDR_W  byte address from CPU
- dat_i  in  16  write data; byte writes use [7:0]
- dat_o  out  16  read data
- we_i  in  1  1=write, 0=read
- byte_i  in  1  1=byte access, 0=word access
- mio_i  in  1  1=memory, 0=I/O
- stb_i  in  1  cycle request
- ack_o  out  1  one-cycle completion pulse
- sram_addr_o  out  ADDR_W  SRAM address
- sram_data_i  in  8  SRAM read data
- sram_data_o  out  8  SRAM write data
- sram_data_oe_o  out  1  drive enable for the SRAM data pins
- sram_ce_n_o  out  1  chip enable, active low
- sram_oe_n_o  out  1  output enable, active low
- sram_we_n_o  out  1  write enable, active low

Behaviour:
- Reset values:
  - ack_o=0, dat_o=0
  - sram_addr_o=0, sram_data_o=0, sram_data_oe_o=0
  - ce_n=oe_n=we_n=1
  - state=IDLE, counter=0
- Reset mid-operation: outputs return to reset values at the next edge. No ack is issued, and no partial write completes beyond the cycle already strobed.
- States: IDLE, B0, R0, B1, R1, ACK.
- IDLE:
  - When stb_i & mio_i are sampled high: latch adr_i, dat_i, we_i, byte_i.
  - Drive sram_addr_o=adr, ce_n=0. On writes, drive sram_data_o=dat[7:0] with oe=1.
  - Go to B0.
  - stb_i & ~mio_i: ignored, stay in IDLE.
- B0 (WAIT_STATES cycles):
  - oe_n=0 on reads; we_n=0 on writes.
  - Address and data are held stable.
  - On a read, sram_data_i is captured into the low byte on the last B0 cycle.
- R0 (1 cycle): strobes high; address and data held (write hold / bus turnaround).
  - byte access: go to ACK.
  - word access: sram_addr_o = adr+1, taken modulo 2^ADDR_W (0xFFFFF wraps to 0x00000); sram_data_o=dat[15:8]; go to B1.
- B1 / R1: same as B0 / R0, for the high byte. R1 goes to ACK.
- ACK (1 cycle):
  - ack_o=1; dat_o valid, with dat_o[15:8]=0 on byte reads.
  - ce_n=1, data_oe=0.
  - Return to IDLE. A new request may be sampled in the cycle after ACK.
- Latency (stb sampled in cycle 0, W=WAIT_STATES):
  - byte access: ack in cycle W+2
  - word access: ack in cycle 2W+3
  - W=2 gives byte 4, word 7.
- stb_i dropped mid-operation: the access still completes and ack still pulses. The SRAM cycle is never aborted.
- Inputs are not re-sampled outside IDLE; changes on adr_i/dat_i during an access are ignored.
- dat_o holds its last value outside ACK.
- we_n and oe_n are never low simultaneously. we_n is never low while data_oe=0.

Decomposition:
- Shared package: state encoding constants, default WAIT_STATES, and the SRAM strobe idle levels.
- One sub-module, wb_sram8_phase: executes a single byte access (setup, strobe for WAIT_STATES, recovery) with start/done handshake and a captured byte.
- The top-level FSM sequences one or two phases and forms ack_o and dat_o.

Test Plan:
- Byte read, W=2, adr=0x01234, SRAM[0x01234]=0xA5 -> oe_n low exactly cycles 1-2, ack_o in cycle 4, dat_o=0x00A5.
- Word write adr=0x00100, dat_i=0xBEEF -> we_n pulses at 0x00100 (data 0xEF) then 0x00101 (data 0xBE), each 2 cycles low, address/data stable 1 cycle after we_n rises, ack in cycle 7.
- Unaligned word read adr=0x12345, SRAM 0x12345=0x34, 0x12346=0x12 -> dat_o=0x1234 on ack.
- Wrap: word read at 0xFFFFF, SRAM[0xFFFFF]=0x11, SRAM[0x00000]=0x22 -> second sram_addr_o=0x00000, dat_o=0x2211.
- I/O cycle stb_i=1, mio_i=0 held 10 cycles -> ce_n stays 1, ack_o never asserted.
- rst_i asserted in cycle 5 of a word write -> next edge: we_n=1, data_oe=0, ce_n=1, no ack; a following byte read completes normally.
